// File: rtl/wb_pipe_stage.sv
`default_nettype none
// ============================================================================
// Module   : wb_pipe_stage
// Brief    : Elastic MEM/WB pipeline stage with valid/ready handshake on both
//            sides, optional two-entry skid buffer, synchronous flush and
//            registered writeback-select / register-file write qualification.
// Revision : 1.0 - initial release
// ============================================================================
module wb_pipe_stage #(
    parameter int XLEN = 32,
    parameter int RD_W = 5,
    parameter int SKID = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_read_data,
    input  logic [XLEN-1:0] in_aluresult,
    input  logic [RD_W-1:0] in_rd,
    input  logic            in_regwrite,
    input  logic            in_memtoreg,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_read_data,
    output logic [XLEN-1:0] out_aluresult,
    output logic [RD_W-1:0] out_rd,
    output logic            out_regwrite,
    output logic            out_memtoreg,
    output logic [XLEN-1:0] out_wb_data,
    output logic            out_rf_we,
    output logic [1:0]      occupancy
);

    // Beat payload packed as {read_data, aluresult, rd, regwrite, memtoreg}
    localparam int c_pay_w = 2 * XLEN + RD_W + 2;

    logic               r_main_v;
    logic [c_pay_w-1:0] r_main;
    logic               w_skid_v;
    logic               w_accept;
    logic               w_consume;
    logic [c_pay_w-1:0] w_in_beat;

    assign w_in_beat = {in_read_data, in_aluresult, in_rd, in_regwrite, in_memtoreg};
    assign w_accept  = in_valid & in_ready;
    assign w_consume = r_main_v & out_ready;

    generate
        if (SKID != 0) begin : g_skid
            logic               r_skid_v;
            logic [c_pay_w-1:0] r_skid;

            // Ready depends only on held state (and reset), never on out_ready
            assign in_ready = ~rst & ~r_skid_v;
            assign w_skid_v = r_skid_v;

            // Main/skid register pair: skid catches a beat arriving under backpressure
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_main_v <= 1'b0;
                    r_skid_v <= 1'b0;
                    r_main   <= '0;
                    r_skid   <= '0;
                end else if (flush) begin
                    r_main_v <= 1'b0;
                    r_skid_v <= 1'b0;
                end else if (r_skid_v) begin
                    // Full: only draining is possible, skid moves into main
                    if (w_consume) begin
                        r_main   <= r_skid;
                        r_skid_v <= 1'b0;
                    end
                end else begin
                    if (w_accept && (!r_main_v || w_consume)) begin
                        r_main   <= w_in_beat;
                        r_main_v <= 1'b1;
                    end else if (w_accept) begin
                        r_skid   <= w_in_beat;
                        r_skid_v <= 1'b1;
                    end else if (w_consume) begin
                        r_main_v <= 1'b0;
                    end
                end
            end
        end else begin : g_noskid
            // Single entry: a new beat may enter in the same cycle the old one leaves
            assign in_ready = ~rst & (~r_main_v | out_ready);
            assign w_skid_v = 1'b0;

            // Single stage register
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_main_v <= 1'b0;
                    r_main   <= '0;
                end else if (flush) begin
                    r_main_v <= 1'b0;
                end else if (w_accept) begin
                    r_main   <= w_in_beat;
                    r_main_v <= 1'b1;
                end else if (w_consume) begin
                    r_main_v <= 1'b0;
                end
            end
        end
    endgenerate

    assign {out_read_data, out_aluresult, out_rd, out_regwrite, out_memtoreg} = r_main;

    assign out_valid   = r_main_v;
    assign out_wb_data = out_memtoreg ? out_read_data : out_aluresult;
    // Bubbles and writes to x0 never reach the register file
    assign out_rf_we   = r_main_v & out_ready & out_regwrite & (out_rd != '0);
    assign occupancy   = {1'b0, r_main_v} + {1'b0, w_skid_v};

endmodule
`default_nettype wire

// File: tb/tb_wb_pipe_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_pipe_stage
// Brief    : Self-checking bench for wb_pipe_stage; SKID=1 and SKID=0
//            instances share stimulus and are compared each cycle against
//            queue-based reference models.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_pipe_stage;

    localparam int XLEN = 32;
    localparam int RD_W = 5;

    typedef struct packed {
        logic [XLEN-1:0] rdata;
        logic [XLEN-1:0] alu;
        logic [RD_W-1:0] rd;
        logic            rw;
        logic            m2r;
    } beat_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst, flush, in_valid, out_ready;
    logic [XLEN-1:0] in_read_data, in_aluresult;
    logic [RD_W-1:0] in_rd;
    logic            in_regwrite, in_memtoreg;

    logic            s_in_ready, s_out_valid, s_out_regwrite, s_out_memtoreg, s_out_rf_we;
    logic [XLEN-1:0] s_out_read_data, s_out_aluresult, s_out_wb_data;
    logic [RD_W-1:0] s_out_rd;
    logic [1:0]      s_occupancy;

    logic            n_in_ready, n_out_valid, n_out_regwrite, n_out_memtoreg, n_out_rf_we;
    logic [XLEN-1:0] n_out_read_data, n_out_aluresult, n_out_wb_data;
    logic [RD_W-1:0] n_out_rd;
    logic [1:0]      n_occupancy;

    wb_pipe_stage #(.XLEN(XLEN), .RD_W(RD_W), .SKID(1)) u_skid (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(s_in_ready),
        .in_read_data(in_read_data), .in_aluresult(in_aluresult), .in_rd(in_rd),
        .in_regwrite(in_regwrite), .in_memtoreg(in_memtoreg),
        .out_valid(s_out_valid), .out_ready(out_ready),
        .out_read_data(s_out_read_data), .out_aluresult(s_out_aluresult), .out_rd(s_out_rd),
        .out_regwrite(s_out_regwrite), .out_memtoreg(s_out_memtoreg),
        .out_wb_data(s_out_wb_data), .out_rf_we(s_out_rf_we), .occupancy(s_occupancy)
    );

    wb_pipe_stage #(.XLEN(XLEN), .RD_W(RD_W), .SKID(0)) u_noskid (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(n_in_ready),
        .in_read_data(in_read_data), .in_aluresult(in_aluresult), .in_rd(in_rd),
        .in_regwrite(in_regwrite), .in_memtoreg(in_memtoreg),
        .out_valid(n_out_valid), .out_ready(out_ready),
        .out_read_data(n_out_read_data), .out_aluresult(n_out_aluresult), .out_rd(n_out_rd),
        .out_regwrite(n_out_regwrite), .out_memtoreg(n_out_memtoreg),
        .out_wb_data(n_out_wb_data), .out_rf_we(n_out_rf_we), .occupancy(n_occupancy)
    );

    // Reference models: FIFO of held beats, capacity 2 (skid) or 1 (no skid)
    beat_t q1[$];
    beat_t q0[$];
    int    checks   = 0;
    int    failures = 0;
    bit    known    = 1'b0;
    bit    prev_rst = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_side(input string nm, input int sz, input beat_t fr,
                              input logic exp_rdy, input logic ordy,
                              input logic rdy, input logic vld, input logic [1:0] occ,
                              input logic we, input logic [XLEN-1:0] wb,
                              input logic [XLEN-1:0] rdat, input logic [XLEN-1:0] alu,
                              input logic [RD_W-1:0] rd, input logic rw, input logic m2r);
        chk({nm, ".in_ready"},  64'(rdy), 64'(exp_rdy));
        chk({nm, ".out_valid"}, 64'(vld), 64'(sz > 0));
        chk({nm, ".occupancy"}, 64'(occ), 64'(sz));
        chk({nm, ".rf_we"},     64'(we),  64'((sz > 0) && ordy && fr.rw && (fr.rd != 0)));
        if (sz > 0) begin
            chk({nm, ".wb_data"},   64'(wb),   64'(fr.m2r ? fr.rdata : fr.alu));
            chk({nm, ".read_data"}, 64'(rdat), 64'(fr.rdata));
            chk({nm, ".aluresult"}, 64'(alu),  64'(fr.alu));
            chk({nm, ".rd"},        64'(rd),   64'(fr.rd));
            chk({nm, ".regwrite"},  64'(rw),   64'(fr.rw));
            chk({nm, ".memtoreg"},  64'(m2r),  64'(fr.m2r));
        end
        if (prev_rst) begin
            chk({nm, ".rst_wb_data"},   64'(wb),  64'(0));
            chk({nm, ".rst_aluresult"}, 64'(alu), 64'(0));
        end
    endtask

    // One clock cycle: drive, check against models, advance models at the edge
    task automatic step(input logic r, input logic f, input logic v, input beat_t b, input logic ordy);
        beat_t f1, f0;
        bit    e1, e0, a1, a0, c1, c0;
        @(negedge clk);
        rst = r; flush = f; in_valid = v; out_ready = ordy;
        in_read_data = b.rdata; in_aluresult = b.alu; in_rd = b.rd;
        in_regwrite = b.rw; in_memtoreg = b.m2r;
        #1;
        f1 = '0; f0 = '0;
        if (q1.size() > 0) f1 = q1[0];
        if (q0.size() > 0) f0 = q0[0];
        e1 = !r && (q1.size() < 2);
        e0 = !r && ((q0.size() == 0) || ordy);
        if (known) begin
            check_side("skid", q1.size(), f1, e1, ordy, s_in_ready, s_out_valid, s_occupancy,
                       s_out_rf_we, s_out_wb_data, s_out_read_data, s_out_aluresult,
                       s_out_rd, s_out_regwrite, s_out_memtoreg);
            check_side("noskid", q0.size(), f0, e0, ordy, n_in_ready, n_out_valid, n_occupancy,
                       n_out_rf_we, n_out_wb_data, n_out_read_data, n_out_aluresult,
                       n_out_rd, n_out_regwrite, n_out_memtoreg);
        end
        a1 = v && e1; c1 = (q1.size() > 0) && ordy;
        a0 = v && e0; c0 = (q0.size() > 0) && ordy;
        @(posedge clk);
        if (r || f) begin
            q1.delete();
            q0.delete();
            if (r) known = 1'b1;
        end else begin
            if (c1) void'(q1.pop_front());
            if (a1) q1.push_back(b);
            if (c0) void'(q0.pop_front());
            if (a0) q0.push_back(b);
        end
        prev_rst = r;
    endtask

    function automatic beat_t rand_beat();
        beat_t b;
        b.rdata = $urandom;
        b.alu   = $urandom;
        b.rd    = ($urandom_range(0, 7) == 0) ? '0 : RD_W'($urandom);
        b.rw    = 1'($urandom_range(0, 3) != 0);
        b.m2r   = 1'($urandom);
        return b;
    endfunction

    beat_t ba, bb, bc, bz, idle;

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_read_data = '0; in_aluresult = '0; in_rd = '0; in_regwrite = 1'b0; in_memtoreg = 1'b0;
        idle = '0;
        ba = '{rdata: 32'h0,    alu: 32'h10, rd: 5'd3, rw: 1'b1, m2r: 1'b0};
        bb = '{rdata: 32'hDEAD, alu: 32'h0,  rd: 5'd4, rw: 1'b1, m2r: 1'b1};
        bc = '{rdata: 32'hBAD0, alu: 32'hC0, rd: 5'd7, rw: 1'b1, m2r: 1'b0};
        bz = '{rdata: 32'h0,    alu: 32'h55, rd: 5'd0, rw: 1'b1, m2r: 1'b0};

        // Reset, then stream A and B with no backpressure
        step(1, 0, 0, idle, 1);
        step(1, 0, 0, idle, 1);
        step(0, 0, 1, ba, 1);
        #1 chk("plan.wb_a", 64'(s_out_wb_data), 64'h10);
        chk("plan.we_a", 64'(s_out_rf_we), 64'd1);
        step(0, 0, 1, bb, 1);
        #1 chk("plan.wb_b", 64'(s_out_wb_data), 64'hDEAD);
        chk("plan.occ_b", 64'(s_occupancy), 64'd1);
        step(0, 0, 0, idle, 1);

        // Backpressure into FULL2, then drain in order
        step(0, 0, 1, ba, 0);
        step(0, 0, 1, bb, 0);
        #1 chk("plan.full2_occ", 64'(s_occupancy), 64'd2);
        chk("plan.full2_rdy", 64'(s_in_ready), 64'd0);
        chk("plan.full2_alu", 64'(s_out_aluresult), 64'h10);
        step(0, 0, 1, bc, 1);
        #1 chk("plan.drain_rdy", 64'(s_in_ready), 64'd1);
        chk("plan.drain_b", 64'(s_out_wb_data), 64'hDEAD);
        step(0, 0, 0, idle, 1);
        step(0, 0, 0, idle, 1);

        // x0 write suppression and idle cycle
        step(0, 0, 1, bz, 1);
        #1 chk("plan.x0_valid", 64'(s_out_valid), 64'd1);
        chk("plan.x0_we", 64'(s_out_rf_we), 64'd0);
        step(0, 0, 0, idle, 1);
        step(0, 0, 0, idle, 1);

        // Flush in FULL2 with a simultaneous incoming beat
        step(0, 0, 1, ba, 0);
        step(0, 0, 1, bb, 0);
        step(0, 1, 1, bc, 0);
        #1 chk("plan.flush_occ", 64'(s_occupancy), 64'd0);
        chk("plan.flush_valid", 64'(s_out_valid), 64'd0);
        chk("plan.flush_rdy", 64'(s_in_ready), 64'd1);
        step(0, 0, 0, idle, 1);

        // Throughput with out_ready toggling 1,0,1
        step(0, 0, 1, ba, 1);
        step(0, 0, 1, bb, 1);
        step(0, 0, 1, bc, 0);
        step(0, 0, 1, bz, 1);
        step(0, 0, 0, idle, 1);

        // Reset mid-operation from FULL2
        step(0, 0, 1, ba, 0);
        step(0, 0, 1, bb, 0);
        step(1, 0, 1, bc, 1);
        #1 chk("plan.rst_occ", 64'(s_occupancy), 64'd0);
        chk("plan.rst_rdy", 64'(s_in_ready), 64'd0);
        chk("plan.rst_wb", 64'(s_out_wb_data), 64'd0);
        step(0, 0, 0, idle, 1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step(1'($urandom_range(0, 63) == 0),
                 1'($urandom_range(0, 31) == 0),
                 1'($urandom_range(0, 9) < 7),
                 rand_beat(),
                 1'($urandom_range(0, 9) < 6));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wb_pipe_stage.md
Name: wb_pipe_stage

Overview:
Parametrised MEM/WB pipeline stage for the 5-stage core. It replaces the free-running stage register with an elastic stage that has:
- a valid/ready handshake on both sides;
- an optional skid buffer;
- a synchronous flush;
- registered writeback-select logic.

It sits between the data-memory stage and the register file write port. It drives the final writeback value and a qualified register-file write enable.

Parameters:
XLEN, 32, width of memory read data, ALU result and writeback value
RD_W, 5, destination-register index width
SKID, 1, 1 = two-entry (main + skid) stage with fully registered in_ready; 0 = single-entry stage with combinational in_ready

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
flush  in  1  discard all held and incoming beats (trap/redirect)
in_valid  in  1  upstream beat valid
in_ready  out  1  stage can accept a beat this cycle
in_read_data  in  XLEN  data-memory read data
in_aluresult  in  XLEN  ALU result from EX/MEM
in_rd  in  RD_W  destination register
in_regwrite  in  1  beat writes the register file
in_memtoreg  in  1  1 = writeback from memory data, 0 = from ALU
out_valid  out  1  output beat valid
out_ready  in  1  downstream accepts the beat
out_read_data  out  XLEN  held memory data
out_aluresult  out  XLEN  held ALU result
out_rd  out  RD_W  held destination register
out_regwrite  out  1  held regwrite
out_memtoreg  out  1  held memtoreg
out_wb_data  out  XLEN  out_memtoreg ? out_read_data : out_aluresult
out_rf_we  out  1  out_valid & out_ready & out_regwrite & (out_rd != 0)
occupancy  out  2  beats held (0..2; max 1 when SKID=0)

Behaviour:
- Reset and clocking
  - One clock, clk. rst is synchronous and active-high.
  - On any rising edge with rst=1: main and skid valid cleared; all payload registers cleared to 0.
  - After reset: out_valid=0, out_rf_we=0, out_wb_data=0, occupancy=0.
  - While rst=1, in_ready=0. In the first cycle after rst deasserts, in_ready=1.
  - Reset mid-transfer drops all beats; no partial beat survives.
- Handshake
  - Beat accepted when in_valid & in_ready.
  - Beat consumed when out_valid & out_ready.
  - Outputs are driven only from the main register. Latency 1 cycle from acceptance to out_valid when the stage is empty.
  - Payload outputs hold stable while out_valid=1 and out_ready=0.
- SKID=1 states, by (main_v, skid_v):
  - EMPTY (0,0): accept -> FULL1.
  - FULL1 (1,0):
    - accept & consume -> FULL1, main reloaded with the new beat;
    - accept & !consume -> FULL2, new beat in skid;
    - consume & !accept -> EMPTY.
  - FULL2 (1,1): in_ready=0. Consume -> FULL1, main<=skid, skid cleared.
  - in_ready = !skid_v, registered (no combinational path from out_ready).
  - in_ready rises in the cycle after the FULL2 drain. No beat is accepted in the drain cycle.
- SKID=0
  - in_ready = !rst & (!out_valid | out_ready).
  - Single register; occupancy is 0 or 1.
- Flush
  - flush=1 at an edge clears both valids. A beat accepted in the same cycle is discarded.
  - Flush has priority over accept and consume; rst has priority over flush.
  - Payload registers need not clear on flush.
  - The cycle after flush: out_valid=0, occupancy=0, in_ready=1.
- Writeback qualification
  - out_rf_we is never 1 when out_valid=0 or out_rd=0. Bubbles and x0 writes are suppressed.
- Ordering
  - Beats exit in acceptance order. None duplicated, none lost except by flush or reset.

Test Plan:
- Reset then stream, SKID=1, out_ready=1. rst 2 cycles, then beats A (alu=0x10, rd=3, regwrite=1, memtoreg=0) and B (mem=0xDEAD, rd=4, memtoreg=1) on consecutive cycles. Required:
  - out_valid=1 one cycle after each accept;
  - out_wb_data = 0x10 then 0xDEAD;
  - out_rf_we=1 both cycles;
  - occupancy=1.
- Backpressure to FULL2. out_ready=0, send A then B. Required:
  - occupancy 1 then 2;
  - in_ready=0 after B;
  - out_aluresult holds A's value.
  Then raise out_ready. Required: A then B exit in order; in_ready=1 the cycle after A drains.
- x0 / bubble suppression. Beat rd=0, regwrite=1. Required: out_valid=1, out_rf_we=0. In an idle cycle, out_rf_we=0 regardless of stale payload.
- Flush with simultaneous accept. Stage in FULL2; flush=1 while in_valid=1. Required: next cycle out_valid=0, occupancy=0, in_ready=1; the flushed beat never appears.
- SKID=0 throughput. out_ready toggling 1,0,1. Required:
  - in_ready follows !out_valid | out_ready combinationally;
  - a new beat is accepted in the same cycle the old one is consumed;
  - occupancy never exceeds 1.
- Reset mid-operation. Stage in FULL2, assert rst for 1 cycle. Required: outputs all 0, occupancy=0, in_ready=0 during rst and 1 after.
